// File: rtl/tiny16_bus_arbiter.sv
// Round-robin arbiter sharing the tiny16 memory/IO bus between NUM_MASTERS requesters.
// Optional bus watchdog enabled by defining BUS_TIMEOUT_EN.
module tiny16_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_MASTERS-1:0]      m_valid,
  input  logic [NUM_MASTERS-1:0]      m_nwr,
  input  logic [16*NUM_MASTERS-1:0]   m_address,
  input  logic [16*NUM_MASTERS-1:0]   m_data_out,
  output logic [15:0]                 m_data_in,
  output logic [NUM_MASTERS-1:0]      m_ready,
  output logic                        s_valid,
  output logic                        s_nwr,
  output logic [15:0]                 s_address,
  output logic [15:0]                 s_data_out,
  input  logic [15:0]                 s_data_in,
  input  logic                        s_ready,
  output logic [NUM_MASTERS-1:0]      grant,
  output logic                        busy,
  output logic                        timeout
);

  localparam int unsigned NM    = NUM_MASTERS;
  localparam int unsigned DW    = 16;
  localparam int unsigned PTR_W = (NM > 1) ? $clog2(NM) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_OWNED   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
`ifdef BUS_TIMEOUT_EN
  localparam logic [1:0] ST_TIMEOUT = 2'd3;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
`endif

  logic [1:0]       r_state,  w_state_nxt;
  logic [NM-1:0]    r_grant,  w_grant_nxt;
  logic [PTR_W-1:0] r_owner,  w_owner_nxt;
  logic [PTR_W-1:0] r_rr_ptr, w_rr_nxt;
`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
`else
  logic [31:0]      w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  logic             w_found;
  logic [PTR_W-1:0] w_pick;
  logic [PTR_W:0]   w_idx;
  logic [PTR_W-1:0] w_rr_adv;
  logic [DW-1:0]    w_addr [NM];
  logic [DW-1:0]    w_wdata[NM];

  // Unflatten the per-master address/data buses
  for (genvar g = 0; g < NM; g++) begin : g_unpack
    assign w_addr[g]  = m_address[DW*g +: DW];
    assign w_wdata[g] = m_data_out[DW*g +: DW];
  end

  // First requester at or after rr_ptr, wrapping at NUM_MASTERS-1
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      w_idx = (PTR_W+1)'(r_rr_ptr) + (PTR_W+1)'(i);
      if (w_idx > (PTR_W+1)'(NM - 1)) begin
        w_idx = w_idx - (PTR_W+1)'(NM);
      end
      if (!w_found && m_valid[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[PTR_W-1:0];
      end
    end
  end

  assign w_rr_adv = (r_owner == PTR_W'(NM - 1)) ? '0 : r_owner + PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
`ifdef BUS_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
`ifdef BUS_TIMEOUT_EN
      r_cnt    <= w_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
`ifdef BUS_TIMEOUT_EN
    w_cnt_nxt   = '0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_OWNED;
          w_grant_nxt = NM'(1) << w_pick;
          w_owner_nxt = w_pick;
        end
      end
      ST_OWNED: begin
        if (!m_valid[r_owner]) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = '0;
          w_rr_nxt    = w_rr_adv;
        end
`ifdef BUS_TIMEOUT_EN
        // Stalled cycle: request is up (owner still valid) but slave not ready
        else if (!s_ready) begin
          if (r_cnt >= CNT_LAST) begin
            w_state_nxt = ST_TIMEOUT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
`endif
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
`ifdef BUS_TIMEOUT_EN
      ST_TIMEOUT: begin
        if (!m_valid[r_owner]) begin
          w_state_nxt = ST_RELEASE;
          w_grant_nxt = '0;
          w_rr_nxt    = w_rr_adv;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Bus forwarding from the owner; everything idles low outside ownership
  always_comb begin
    s_valid    = 1'b0;
    s_nwr      = 1'b0;
    s_address  = '0;
    s_data_out = '0;
    m_ready    = '0;
    m_data_in  = s_data_in;
    busy       = 1'b0;
    timeout    = 1'b0;
    case (r_state)
      ST_OWNED: begin
        s_valid          = m_valid[r_owner];
        s_nwr            = m_nwr[r_owner];
        s_address        = w_addr[r_owner];
        s_data_out       = w_wdata[r_owner];
        m_ready[r_owner] = s_ready;
        busy             = 1'b1;
      end
`ifdef BUS_TIMEOUT_EN
      ST_TIMEOUT: begin
        s_nwr            = m_nwr[r_owner];
        s_address        = w_addr[r_owner];
        s_data_out       = w_wdata[r_owner];
        m_ready[r_owner] = 1'b1;
        m_data_in        = 16'hFFFF;
        busy             = 1'b1;
        timeout          = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign grant = r_grant;

endmodule

// File: tb/tb_tiny16_bus_arbiter.sv
// Self-checking bench for tiny16_bus_arbiter (two masters); timeout sequence runs when BUS_TIMEOUT_EN is defined.
module tb_tiny16_bus_arbiter;

  localparam logic [15:0] A0 = 16'h1234;
  localparam logic [15:0] A1 = 16'h5678;
  localparam logic [15:0] D0 = 16'hAAAA;
  localparam logic [15:0] D1 = 16'h5555;

  typedef struct packed {
    logic [1:0]  grant;
    logic        s_valid;
    logic        s_nwr;
    logic [15:0] s_address;
    logic [15:0] s_data_out;
    logic [1:0]  m_ready;
    logic        busy;
    logic        timeout;
    logic [15:0] m_data_in;
  } out_t;

  typedef struct {
    logic [1:0]  mv;
    logic [1:0]  nwr;
    logic        srdy;
    logic [15:0] sdin;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [1:0]  m_valid;
  logic [1:0]  m_nwr;
  logic [31:0] m_address;
  logic [31:0] m_data_out;
  logic [15:0] m_data_in;
  logic [1:0]  m_ready;
  logic        s_valid;
  logic        s_nwr;
  logic [15:0] s_address;
  logic [15:0] s_data_out;
  logic [15:0] s_data_in;
  logic        s_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout;

  int   n_vec;
  int   n_miss;
  out_t sb_q[$];
  vec_t tbl[$];

  tiny16_bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .m_valid    (m_valid),
    .m_nwr      (m_nwr),
    .m_address  (m_address),
    .m_data_out (m_data_out),
    .m_data_in  (m_data_in),
    .m_ready    (m_ready),
    .s_valid    (s_valid),
    .s_nwr      (s_nwr),
    .s_address  (s_address),
    .s_data_out (s_data_out),
    .s_data_in  (s_data_in),
    .s_ready    (s_ready),
    .grant      (grant),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs; slave-side fields follow whichever master the grant names
  function automatic out_t mk(input logic [1:0] g, input logic sv, input logic [1:0] nwr,
                              input logic [1:0] mr, input logic bz, input logic to,
                              input logic [15:0] mdi);
    out_t o;
    o            = '0;
    o.grant      = g;
    o.s_valid    = sv;
    o.m_ready    = mr;
    o.busy       = bz;
    o.timeout    = to;
    o.m_data_in  = mdi;
    if (g == 2'b01) begin
      o.s_nwr = nwr[0]; o.s_address = A0; o.s_data_out = D0;
    end else if (g == 2'b10) begin
      o.s_nwr = nwr[1]; o.s_address = A1; o.s_data_out = D1;
    end
    return o;
  endfunction

  function automatic vec_t row(input logic [1:0] mv, input logic [1:0] nwr, input logic srdy,
                               input logic [15:0] sdin, input logic [1:0] g, input logic sv,
                               input logic [1:0] mr, input logic bz, input logic to,
                               input logic [15:0] mdi);
    vec_t v;
    v.mv = mv; v.nwr = nwr; v.srdy = srdy; v.sdin = sdin;
    v.exp = mk(g, sv, nwr, mr, bz, to, mdi);
    return v;
  endfunction

  task automatic check(input string name);
    out_t exp;
    out_t act;
    exp = sb_q.pop_front();
    act = {grant, s_valid, s_nwr, s_address, s_data_out, m_ready, busy, timeout, m_data_in};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got grant=%b sv=%b nwr=%b addr=%h wd=%h rdy=%b busy=%b to=%b rd=%h, exp grant=%b sv=%b nwr=%b addr=%h wd=%h rdy=%b busy=%b to=%b rd=%h",
               name, act.grant, act.s_valid, act.s_nwr, act.s_address, act.s_data_out,
               act.m_ready, act.busy, act.timeout, act.m_data_in,
               exp.grant, exp.s_valid, exp.s_nwr, exp.s_address, exp.s_data_out,
               exp.m_ready, exp.busy, exp.timeout, exp.m_data_in);
    end
  endtask

  // Drive on the falling edge, sample 1ns after the rising edge
  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    m_valid   = v.mv;
    m_nwr     = v.nwr;
    s_ready   = v.srdy;
    s_data_in = v.sdin;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    reset      = 1'b1;
    m_valid    = '0;
    m_nwr      = '0;
    m_address  = {A1, A0};
    m_data_out = {D1, D0};
    s_data_in  = '0;
    s_ready    = 1'b0;

    //                 mv     nwr    rdy   sdin      grant  sv    rdy    busy  to    rd
    tbl.push_back(row(2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b01, 2'b00, 1'b0, 16'h1111, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 16'h1111));
    tbl.push_back(row(2'b01, 2'b00, 1'b0, 16'h2222, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 16'h2222));
    tbl.push_back(row(2'b01, 2'b00, 1'b1, 16'hBEEF, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 16'hBEEF));
    tbl.push_back(row(2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b11, 2'b10, 1'b0, 16'h0000, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000));
    tbl.push_back(row(2'b11, 2'b10, 1'b1, 16'h1357, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 16'h1357));
    tbl.push_back(row(2'b01, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b01, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b01, 2'b10, 1'b1, 16'hCAFE, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 16'hCAFE));
    tbl.push_back(row(2'b00, 2'b10, 1'b1, 16'hCAFE, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'hCAFE));
    tbl.push_back(row(2'b10, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b11, 2'b10, 1'b0, 16'h0000, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000));
    tbl.push_back(row(2'b11, 2'b10, 1'b1, 16'h2468, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 16'h2468));
    tbl.push_back(row(2'b01, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b01, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b11, 2'b10, 1'b0, 16'h0000, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000));
    tbl.push_back(row(2'b10, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b10, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b10, 2'b10, 1'b1, 16'h9999, 2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 16'h9999));
    tbl.push_back(row(2'b00, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(row(2'b00, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000));

    // Outputs held at zero while in reset
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000));
    check("reset_state");
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

    // Move rr_ptr to 1, then reset asynchronously while master 1 owns the bus
    step(row(2'b01, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000), "pre_rst_own0");
    step(row(2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000), "pre_rst_rel");
    step(row(2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000), "pre_rst_idle");
    step(row(2'b10, 2'b10, 1'b0, 16'h0000, 2'b10, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000), "pre_rst_own1");
    @(negedge clk);
    m_valid = 2'b11;
    s_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    sb_q.push_back(mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000));
    check("async_reset_mid_owned");
    @(posedge clk);
    #1;
    sb_q.push_back(mk(2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000));
    check("reset_held_edge");
    @(negedge clk);
    m_valid = 2'b00;
    reset   = 1'b0;
    step(row(2'b11, 2'b10, 1'b1, 16'h0000, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 16'h0000), "post_rst_rr0");
    step(row(2'b00, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000), "post_rst_rel");
    step(row(2'b00, 2'b10, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000), "post_rst_idle");

`ifdef BUS_TIMEOUT_EN
    // Four stalled cycles force a completion with all-ones read data
    step(row(2'b01, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000), "to_grant");
    for (int k = 0; k < 3; k++)
      step(row(2'b01, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000), $sformatf("to_stall%0d", k));
    step(row(2'b01, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 16'hFFFF), "to_fire");
    step(row(2'b01, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 16'hFFFF), "to_hold");
    step(row(2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000), "to_release");
    step(row(2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000), "to_idle");
`else
    // Without the watchdog a stalled slave is waited on indefinitely
    step(row(2'b01, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000), "stall_grant");
    for (int k = 0; k < 8; k++)
      step(row(2'b01, 2'b00, 1'b0, 16'h0000, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 16'h0000), $sformatf("stall%0d", k));
    step(row(2'b01, 2'b00, 1'b1, 16'h4321, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 16'h4321), "stall_done");
    step(row(2'b00, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000), "stall_release");
`endif

    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending, exp 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tiny16_bus_arbiter.md
Name: tiny16_bus_arbiter

Overview:
- Round-robin arbiter that shares the single tiny16 external memory/IO bus (address, data_in, data_out, mem_valid, nwr, mem_ready) between NUM_MASTERS requesters: the tiny16 core plus DMA or peripheral engines.
- Sits between the masters and the IO/peripheral decoder.
- Grants the bus to one master per ownership period and forwards its request to the slave side.
- Routes slave ready/data back to the owner.

Parameters:
- NUM_MASTERS, 2, number of requesters (1..8).
- TIMEOUT_CYCLES, 255, cycles without s_ready before a forced completion (used only with BUS_TIMEOUT_EN).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- m_valid  input  NUM_MASTERS  per-master request; held high until ready is seen.
- m_nwr  input  NUM_MASTERS  per-master direction, same encoding as the core's nwr.
- m_address  input  16*NUM_MASTERS  flattened per-master address; master i at [16*i+15:16*i].
- m_data_out  input  16*NUM_MASTERS  flattened per-master write data.
- m_data_in  output  16  read data, broadcast to all masters.
- m_ready  output  NUM_MASTERS  per-master ready.
- s_valid  output  1  slave-side request.
- s_nwr  output  1  slave-side direction.
- s_address  output  16  slave-side address.
- s_data_out  output  16  slave-side write data.
- s_data_in  input  16  slave read data.
- s_ready  input  1  slave ready (level).
- grant  output  NUM_MASTERS  one-hot current owner; registered.
- busy  output  1  high in OWNED or TIMEOUT.
- timeout  output  1  high while in TIMEOUT state (tied 0 without BUS_TIMEOUT_EN).

Behaviour:
- Reset (async, active-high): state=IDLE, grant=0, rr_ptr=0, timeout counter=0. All outputs 0: s_valid, s_nwr, s_address, s_data_out, m_ready, busy, timeout. m_data_in=0 only if s_data_in=0 (pure pass-through). Reset mid-transaction drops s_valid immediately; there is no completion to the owner.
- States: IDLE, OWNED, RELEASE, TIMEOUT (optional).
- IDLE:
  - If any m_valid is high at a posedge, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... mod NUM_MASTERS).
  - Register the one-hot grant and go to OWNED.
  - If no m_valid is high, stay in IDLE with grant=0.
- Arbitration latency: m_valid sampled high at edge k -> grant and s_valid high after edge k. Minimum one cycle from request to s_valid.
- OWNED (combinational forwarding from owner):
  - s_valid = m_valid[owner]; s_nwr, s_address, s_data_out = owner's fields.
  - m_ready[owner] = s_ready; m_ready of every other master = 0.
  - m_data_in = s_data_in at all times.
- Release: owner's m_valid sampled low in OWNED -> RELEASE, rr_ptr <= (owner+1) mod NUM_MASTERS. Early drop (abort before s_ready) is legal and handled the same way.
- Back-to-back transactions: a master must drop m_valid between transactions, which always costs one RELEASE cycle. There is no bus locking.
- RELEASE: grant=0, s_valid=0 for exactly one cycle, then IDLE. This guarantees the slave sees s_valid low between owners.
- Simultaneous requests: round-robin order only; no fixed priority. With rr_ptr=0 and all requesting, order is 0,1,...,N-1,0.
- Requests arriving during OWNED or RELEASE wait. Non-owners never see m_ready.
- NUM_MASTERS=1: same FSM; grant is 1 bit; rr_ptr stays 0.
- Pointer width is $clog2(NUM_MASTERS), minimum 1. Wrap uses explicit compare to NUM_MASTERS-1, not power-of-two overflow.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- With it defined:
  - Counter increments each OWNED cycle where s_valid=1 and s_ready=0; it clears on s_ready=1 or on leaving OWNED.
  - When the counter reaches TIMEOUT_CYCLES, go to TIMEOUT.
  - In TIMEOUT: s_valid=0, m_ready[owner]=1, m_data_in=16'hFFFF, timeout=1, busy=1.
  - Leave TIMEOUT to RELEASE (with the normal rr_ptr advance) when the owner's m_valid drops.
- Without it: no counter, no TIMEOUT state, timeout output tied 0, and the arbiter waits indefinitely for s_ready.

Test Plan:
- Single master 0: m_valid[0]=1, addr 16'h1234, nwr=0, s_ready high 2 cycles later -> grant=01 one edge after request; s_address=16'h1234; m_ready[0]=1 with s_data_in value; m_valid drop -> one RELEASE cycle with s_valid=0.
- Both masters request at the same edge after reset -> master 0 granted first. After master 0 releases, master 1 is granted on the edge following RELEASE; m_ready[1] is never high while grant=01.
- Master 1 requests continuously, master 0 requests repeatedly -> grants alternate 01,10,01,10; neither master is starved.
- Owner aborts (drops m_valid before s_ready) -> RELEASE next cycle, rr_ptr advances, s_valid low; a pending master gets granted after IDLE.
- Assert reset during OWNED with s_valid=1 -> s_valid, grant, m_ready and busy go 0 immediately without waiting for a clock edge; first request after reset is arbitrated from rr_ptr=0.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and s_ready held 0 -> after 4 stalled cycles: timeout=1, m_ready[owner]=1, m_data_in=16'hFFFF; owner drops m_valid -> RELEASE, timeout=0.
